// File: rtl/csram_stream_loader.sv
// Neuron-config SRAM loaded from a narrow beat stream; optional parity via CSRAM_PARITY_EN.
// Latency: entry commits one cycle after its last beat, reads return registered data one cycle later.
// Backpressure: cfg_ready drops during commit; rd_en stalls a pending commit for as long as it is held.
module csram_stream_loader #(
  parameter int CORE_IDX    = 0,
  parameter int NUM_NEURONS = 256,
  parameter int WIDTH       = 367,
  parameter int WRITE_WIDTH = 9,
  localparam int AW         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic [AW-1:0]          cfg_base,
  input  logic                   cfg_valid,
  input  logic [WRITE_WIDTH-1:0] cfg_data,
  output logic                   cfg_ready,
  output logic                   cfg_entry_done,
  output logic [AW-1:0]          wr_ptr,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
`ifdef CSRAM_PARITY_EN
  input  logic                   inj_parity_err,
  output logic                   rd_parity_err,
`endif
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid
);

  localparam int BEATS = (WIDTH + WRITE_WIDTH - 1) / WRITE_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef CSRAM_PARITY_EN
  localparam int MW    = WIDTH + 1;
`else
  localparam int MW    = WIDTH;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_COMMIT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [BCW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [WIDTH-1:0] r_asm, w_asm_nxt;
  logic [AW-1:0]    r_wr_ptr, w_wr_ptr_nxt;
  logic             w_commit;
  logic             r_entry_done;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic [MW-1:0]    w_wr_word;
  logic [MW-1:0]    w_rd_word;
  logic [MW-1:0]    r_mem [NUM_NEURONS];

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_asm_nxt      = r_asm;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_commit       = 1'b0;
    // cfg_start wins over any beat or commit in the same cycle
    if (cfg_start) begin
      w_state_nxt    = S_ASSEMBLE;
      w_beat_cnt_nxt = '0;
      w_asm_nxt      = '0;
      w_wr_ptr_nxt   = cfg_base;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_ASSEMBLE: begin
          if (cfg_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
              if (BCW'(i / WRITE_WIDTH) == r_beat_cnt) begin
                w_asm_nxt[i] = cfg_data[i % WRITE_WIDTH];
              end
            end
            if (r_beat_cnt == BCW'(BEATS - 1)) begin
              w_state_nxt = S_COMMIT;
            end else begin
              w_beat_cnt_nxt = r_beat_cnt + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          if (!rd_en) begin
            w_commit       = 1'b1;
            w_beat_cnt_nxt = '0;
            w_state_nxt    = S_ASSEMBLE;
            w_wr_ptr_nxt   = (r_wr_ptr == AW'(NUM_NEURONS - 1)) ? '0 : r_wr_ptr + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_beat_cnt   <= '0;
      r_asm        <= '0;
      r_wr_ptr     <= '0;
      r_entry_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_asm        <= w_asm_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_entry_done <= w_commit;
    end
  end

`ifdef CSRAM_PARITY_EN
  // Stored bit makes the whole word even; the inject hook flips it to fake corruption
  assign w_wr_word = {(^r_asm) ^ inj_parity_err, r_asm};
`else
  assign w_wr_word = r_asm;
`endif

  always_ff @(posedge clk) begin
    if (rst_n && w_commit) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  assign w_rd_word = r_mem[rd_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_word[WIDTH-1:0];
      end
    end
  end

`ifdef CSRAM_PARITY_EN
  logic r_rd_parity_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_parity_err <= 1'b0;
    end else if (rd_en) begin
      r_rd_parity_err <= ^w_rd_word;
    end
  end

  assign rd_parity_err = r_rd_parity_err;
`endif

  assign cfg_ready      = (r_state == S_ASSEMBLE);
  assign cfg_entry_done = r_entry_done;
  assign wr_ptr         = r_wr_ptr;
  assign rd_data        = r_rd_data;
  assign rd_valid       = r_rd_valid;

endmodule

// File: tb/tb_csram_stream_loader.sv
// Directed bench for csram_stream_loader at WIDTH=20, WRITE_WIDTH=8, NUM_NEURONS=4 (3 beats/entry).
module tb_csram_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [1:0]  cfg_base;
  logic        cfg_valid;
  logic [7:0]  cfg_data;
  logic        cfg_ready;
  logic        cfg_entry_done;
  logic [1:0]  wr_ptr;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [19:0] rd_data;
  logic        rd_valid;
`ifdef CSRAM_PARITY_EN
  logic        inj_parity_err;
  logic        rd_parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csram_stream_loader #(
    .CORE_IDX    (0),
    .NUM_NEURONS (4),
    .WIDTH       (20),
    .WRITE_WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .cfg_base       (cfg_base),
    .cfg_valid      (cfg_valid),
    .cfg_data       (cfg_data),
    .cfg_ready      (cfg_ready),
    .cfg_entry_done (cfg_entry_done),
    .wr_ptr         (wr_ptr),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
`ifdef CSRAM_PARITY_EN
    .inj_parity_err (inj_parity_err),
    .rd_parity_err  (rd_parity_err),
`endif
    .rd_data        (rd_data),
    .rd_valid       (rd_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] base);
    cfg_start = 1'b1;
    cfg_base  = base;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic read(input logic [1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_ready: got %b want 0", cfg_ready); end
    n_checks++; if (cfg_entry_done !== 1'b0) begin n_fail++; $display("FAIL reset_entry_done: got %b want 0", cfg_entry_done); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (rd_data !== 20'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00000", rd_data); end
    n_checks++; if (wr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_wr_ptr: got %0d want 0", wr_ptr); end
    rst_n = 1'b1;
    beat(8'hAA);
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL idle_cfg_ready: got %b want 0", cfg_ready); end
    tick();
    n_checks++; if (cfg_entry_done !== 1'b0) begin n_fail++; $display("FAIL idle_no_commit: got %b want 0", cfg_entry_done); end
  endtask

  task automatic test_basic_load();
    start(2'd1);
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", cfg_ready); end
    n_checks++; if (wr_ptr !== 2'd1) begin n_fail++; $display("FAIL basic_ptr_load: got %0d want 1", wr_ptr); end
    beat(8'h34);
    beat(8'h12);
    beat(8'hFA);
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL basic_commit_ready: got %b want 0", cfg_ready); end
    tick();
    n_checks++; if (cfg_entry_done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", cfg_entry_done); end
    n_checks++; if (wr_ptr !== 2'd2) begin n_fail++; $display("FAIL basic_ptr_inc: got %0d want 2", wr_ptr); end
    tick();
    n_checks++; if (cfg_entry_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", cfg_entry_done); end
    read(2'd1);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rd_valid: got %b want 1", rd_valid); end
    n_checks++; if (rd_data !== 20'hA1234) begin n_fail++; $display("FAIL basic_rd_data: got %h want A1234", rd_data); end
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rd_valid_drop: got %b want 0", rd_valid); end
    n_checks++; if (rd_data !== 20'hA1234) begin n_fail++; $display("FAIL basic_rd_hold: got %h want A1234", rd_data); end
  endtask

  task automatic test_wrap();
    start(2'd3);
    beat(8'h01); beat(8'h00); beat(8'h00);
    tick();
    n_checks++; if (wr_ptr !== 2'd0) begin n_fail++; $display("FAIL wrap_ptr0: got %0d want 0", wr_ptr); end
    beat(8'h02); beat(8'h00); beat(8'h00);
    tick();
    n_checks++; if (wr_ptr !== 2'd1) begin n_fail++; $display("FAIL wrap_ptr1: got %0d want 1", wr_ptr); end
    read(2'd3);
    n_checks++; if (rd_data !== 20'h00001) begin n_fail++; $display("FAIL wrap_mem3: got %h want 00001", rd_data); end
    read(2'd0);
    n_checks++; if (rd_data !== 20'h00002) begin n_fail++; $display("FAIL wrap_mem0: got %h want 00002", rd_data); end
  endtask

  task automatic test_read_stall();
    // pointer is 1 here; overwrite entry 1 while reads hold the commit off
    beat(8'hEF); beat(8'hCD); beat(8'h0B);
    rd_en   = 1'b1;
    rd_addr = 2'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", k, cfg_ready); end
      n_checks++; if (cfg_entry_done !== 1'b0) begin n_fail++; $display("FAIL stall_done[%0d]: got %b want 0", k, cfg_entry_done); end
      n_checks++; if (rd_data !== 20'hA1234) begin n_fail++; $display("FAIL stall_old_data[%0d]: got %h want A1234", k, rd_data); end
    end
    rd_en = 1'b0;
    tick();
    n_checks++; if (cfg_entry_done !== 1'b1) begin n_fail++; $display("FAIL stall_release_done: got %b want 1", cfg_entry_done); end
    n_checks++; if (wr_ptr !== 2'd2) begin n_fail++; $display("FAIL stall_release_ptr: got %0d want 2", wr_ptr); end
    read(2'd1);
    n_checks++; if (rd_data !== 20'hBCDEF) begin n_fail++; $display("FAIL stall_new_data: got %h want BCDEF", rd_data); end
  endtask

  task automatic test_abort();
    start(2'd0);
    beat(8'h11); beat(8'h22);
    start(2'd2);
    n_checks++; if (cfg_entry_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", cfg_entry_done); end
    n_checks++; if (wr_ptr !== 2'd2) begin n_fail++; $display("FAIL abort_ptr: got %0d want 2", wr_ptr); end
    beat(8'h33); beat(8'h44); beat(8'h05);
    tick();
    n_checks++; if (wr_ptr !== 2'd3) begin n_fail++; $display("FAIL abort_ptr_after: got %0d want 3", wr_ptr); end
    read(2'd0);
    n_checks++; if (rd_data !== 20'h00002) begin n_fail++; $display("FAIL abort_old_untouched: got %h want 00002", rd_data); end
    read(2'd2);
    n_checks++; if (rd_data !== 20'h54433) begin n_fail++; $display("FAIL abort_new_entry: got %h want 54433", rd_data); end
  endtask

  task automatic test_reset_mid();
    cfg_valid = 1'b1;
    cfg_data  = 8'h77;
    rd_en     = 1'b1;
    rd_addr   = 2'd3;
    tick();
    cfg_valid = 1'b0;
    rd_en     = 1'b0;
    n_checks++; if (rd_data !== 20'h00001) begin n_fail++; $display("FAIL mid_pre_read: got %h want 00001", rd_data); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", cfg_ready); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (rd_data !== 20'h0) begin n_fail++; $display("FAIL mid_rd_data: got %h want 00000", rd_data); end
    n_checks++; if (wr_ptr !== 2'd0) begin n_fail++; $display("FAIL mid_wr_ptr: got %0d want 0", wr_ptr); end
    rst_n = 1'b1;
    read(2'd1);
    n_checks++; if (rd_data !== 20'hBCDEF) begin n_fail++; $display("FAIL mid_keep1: got %h want BCDEF", rd_data); end
    read(2'd2);
    n_checks++; if (rd_data !== 20'h54433) begin n_fail++; $display("FAIL mid_keep2: got %h want 54433", rd_data); end
    read(2'd3);
    n_checks++; if (rd_data !== 20'h00001) begin n_fail++; $display("FAIL mid_keep3: got %h want 00001", rd_data); end
  endtask

`ifdef CSRAM_PARITY_EN
  task automatic test_parity();
    start(2'd0);
    beat(8'h01); beat(8'h00); beat(8'h00);
    inj_parity_err = 1'b1;
    tick();
    inj_parity_err = 1'b0;
    read(2'd0);
    n_checks++; if (rd_parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_injected: got %b want 1", rd_parity_err); end
    start(2'd0);
    beat(8'h01); beat(8'h00); beat(8'h00);
    tick();
    read(2'd0);
    n_checks++; if (rd_parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_clean: got %b want 0", rd_parity_err); end
    n_checks++; if (rd_data !== 20'h00001) begin n_fail++; $display("FAIL parity_data: got %h want 00001", rd_data); end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_base  = 2'd0;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    rd_en     = 1'b0;
    rd_addr   = 2'd0;
`ifdef CSRAM_PARITY_EN
    inj_parity_err = 1'b0;
`endif
    test_reset();
    test_basic_load();
    test_wrap();
    test_read_stall();
    test_abort();
    test_reset_mid();
`ifdef CSRAM_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
